// File: rtl/pixel_group_scheduler_if.sv
// Event stream from the pixel group scheduler to its consumer.
interface pixel_group_scheduler_if #(
   parameter int XW = 4,
   parameter int YW = 4
);
   logic          valid;
   logic          ready;
   logic [XW-1:0] x;
   logic [YW-1:0] y;

   modport master (output valid, output x, output y, input ready);
   modport slave  (input valid, input x, input y, output ready);
endinterface

// File: rtl/pixel_group_scheduler.sv
// Round-robin level-0 group scheduler with (x,y) event FIFO.
// Optional watchdog release: define PIXEL_SCHED_WDOG_EN.
module pixel_group_scheduler #(
   parameter int GRP_ROWS    = 4,
   parameter int GRP_COLS    = 4,
   parameter int LVL0_ADD_W  = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int WDOG_CYCLES = 64
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]  req_i,
   input  logic                               active_i,
   input  logic                               grp_release_i,
   input  logic [LVL0_ADD_W-1:0]              x_add_i,
   input  logic [LVL0_ADD_W-1:0]              y_add_i,
   output logic [GRP_ROWS-1:0][GRP_COLS-1:0]  enable_o,
   pixel_group_scheduler_if.master            evt,
   output logic                               busy_o,
   output logic                               overflow_o
`ifdef PIXEL_SCHED_WDOG_EN
   ,
   output logic                               wdog_o
`endif
);
   localparam int N    = GRP_ROWS * GRP_COLS;
   localparam int GW   = (N > 1) ? $clog2(N) : 1;
   localparam int RW   = $clog2(GRP_ROWS);
   localparam int CW   = $clog2(GRP_COLS);
   localparam int XW   = RW + LVL0_ADD_W;
   localparam int YW   = CW + LVL0_ADD_W;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_win;
   logic [GW-1:0]   r_ptr;
   logic            r_ovf;
   logic [CNTW-1:0] r_cnt;
   logic [PW-1:0]   r_wr;
   logic [PW-1:0]   r_rd;
   logic [XW-1:0]   r_mem_x [FIFO_DEPTH];
   logic [YW-1:0]   r_mem_y [FIFO_DEPTH];

   logic [N-1:0]    w_req;
   logic [GW-1:0]   w_pick;
   logic            w_any;
   logic            w_room;
   logic            w_full;
   logic            w_valid;
   logic            w_pop;
   logic            w_push_req;
   logic            w_push;
   logic            w_drop;
   logic [CNTW-1:0] w_cnt_nxt;
   logic [RW-1:0]   w_row;
   logic [CW-1:0]   w_col;

   assign w_req = req_i;

   // Lowest offset above the pointer wins, so scan offsets downward.
   always_comb begin
      int idx;
      idx    = 0;
      w_pick = r_ptr;
      w_any  = 1'b0;
      for (int i = N; i >= 1; i--) begin
         idx = (int'(r_ptr) + i) % N;
         if (w_req[idx]) begin
            w_pick = GW'(idx);
            w_any  = 1'b1;
         end
      end
   end

   assign w_room     = int'(r_cnt) <= FIFO_DEPTH - 2;
   assign w_full     = int'(r_cnt) == FIFO_DEPTH;
   assign w_valid    = r_cnt != '0;
   assign w_pop      = w_valid && evt.ready;
   assign w_push_req = (r_state == S_GRANT) && active_i;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop)
         w_cnt_nxt = r_cnt + CNTW'(1);
      else if (w_pop && !w_push)
         w_cnt_nxt = r_cnt - CNTW'(1);
   end

   assign w_row = RW'(int'(r_win) / GRP_COLS);
   assign w_col = CW'(int'(r_win) % GRP_COLS);

   assign enable_o  = (r_state == S_GRANT && w_room)
                    ? (N'(1) << r_win) : '0;
   assign busy_o     = r_state != S_IDLE;
   assign overflow_o = r_ovf;
   assign evt.valid  = w_valid;
   assign evt.x      = r_mem_x[r_rd];
   assign evt.y      = r_mem_y[r_rd];

`ifdef PIXEL_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] r_wd;
   logic          r_wdog;
   assign wdog_o = r_wdog;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_win   <= '0;
         r_ptr   <= GW'(N - 1);
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
`ifdef PIXEL_SCHED_WDOG_EN
         r_wd    <= '0;
         r_wdog  <= 1'b0;
`endif
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_push) begin
            r_mem_x[r_wr] <= {w_row, x_add_i};
            r_mem_y[r_wr] <= {w_col, y_add_i};
            r_wr          <= r_wr + PW'(1);
         end
         if (w_pop)
            r_rd <= r_rd + PW'(1);
         if (w_drop)
            r_ovf <= 1'b1;
`ifdef PIXEL_SCHED_WDOG_EN
         r_wdog <= 1'b0;
`endif
         unique case (r_state)
            S_IDLE: begin
               if (w_any && w_room) begin
                  r_win   <= w_pick;
                  r_state <= S_GRANT;
`ifdef PIXEL_SCHED_WDOG_EN
                  r_wd    <= '0;
`endif
               end
            end
            S_GRANT: begin
               if (grp_release_i) begin
                  r_ptr   <= r_win;
                  r_state <= S_GAP;
`ifdef PIXEL_SCHED_WDOG_EN
               end else if (int'(r_wd) == WDOG_CYCLES - 1) begin
                  r_ptr   <= r_win;
                  r_state <= S_GAP;
                  r_wdog  <= 1'b1;
               end else begin
                  r_wd    <= r_wd + WW'(1);
`endif
               end
            end
            S_GAP:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_group_scheduler.sv
// Directed + randomized bench for pixel_group_scheduler (4x4 groups, 2-bit address).
module tb_pixel_group_scheduler;
   logic           clk = 1'b0;
   logic           reset_i;
   logic [3:0][3:0] req;
   logic           active;
   logic           rel;
   logic [1:0]     xa;
   logic [1:0]     ya;
   logic [3:0][3:0] en;
   logic           busy;
   logic           ovf;
`ifdef PIXEL_SCHED_WDOG_EN
   logic           wdog;
`endif

   int checks = 0;
   int errors = 0;
   int ptr;
   int evq_x[$];
   int evq_y[$];

   pixel_group_scheduler_if #(.XW(4), .YW(4)) evt_if ();

   pixel_group_scheduler dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .req_i        (req),
      .active_i     (active),
      .grp_release_i(rel),
      .x_add_i      (xa),
      .y_add_i      (ya),
      .enable_o     (en),
      .evt          (evt_if),
      .busy_o       (busy),
      .overflow_o   (ovf)
`ifdef PIXEL_SCHED_WDOG_EN
      ,
      .wdog_o       (wdog)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(int p, logic [15:0] m);
      for (int i = 1; i <= 16; i++)
         if (m[(p + i) % 16]) return (p + i) % 16;
      return -1;
   endfunction

   function automatic logic [15:0] onehot(int g);
      logic [15:0] v;
      v = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // Push the current address of group g into the expected queue.
   task automatic model_push(int g);
      evq_x.push_back((g / 4) * 4 + int'(xa));
      evq_y.push_back((g % 4) * 4 + int'(ya));
   endtask

   task automatic chk_head(string tag);
      chk({tag, "_v"}, 64'(evt_if.valid), 64'(1));
      chk({tag, "_x"}, 64'(evt_if.x), 64'(evq_x[0]));
      chk({tag, "_y"}, 64'(evt_if.y), 64'(evq_y[0]));
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      ptr = 15;
      evq_x.delete();
      evq_y.delete();
   endtask

   task automatic drain(string tag);
      evt_if.ready = 1'b1;
      while (evq_x.size() > 0) begin
         chk_head(tag);
         tick();
         void'(evq_x.pop_front());
         void'(evq_y.pop_front());
      end
      chk({tag, "_empty"}, 64'(evt_if.valid), 64'(0));
      evt_if.ready = 1'b0;
   endtask

   initial begin
      int g;
      int n;
      logic [15:0] m;
      logic done;
      req = '0; active = 0; rel = 0; xa = 0; ya = 0;
      evt_if.ready = 1'b0;
      reset_i = 1'b1;
      tick();
      tick();
      chk("rst_en", 64'(en), 64'(0));
      chk("rst_valid", 64'(evt_if.valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      reset_i = 1'b0;
      ptr = 15;

      // Group 5 alone: two events
      req = 16'(onehot(5));
      tick();
      chk("g5_en", 64'(en), 64'(onehot(5)));
      chk("g5_busy", 64'(busy), 64'(1));
      active = 1; xa = 1; ya = 2;
      tick();
      chk("g5_e0x", 64'(evt_if.x), 64'(5));
      chk("g5_e0y", 64'(evt_if.y), 64'(6));
      xa = 3; ya = 0;
      tick();
      active = 0;
      chk("g5_hold_x", 64'(evt_if.x), 64'(5));
      evt_if.ready = 1'b1;
      tick();
      chk("g5_e1x", 64'(evt_if.x), 64'(7));
      chk("g5_e1y", 64'(evt_if.y), 64'(4));
      tick();
      chk("g5_empty", 64'(evt_if.valid), 64'(0));
      evt_if.ready = 1'b0;
      rel = 1;
      tick();
      rel = 0; req = '0;
      chk("g5_gap_en", 64'(en), 64'(0));
      chk("g5_gap_busy", 64'(busy), 64'(1));
      tick();
      chk("g5_idle", 64'(busy), 64'(0));

      // Round robin over groups 0, 3, 15
      do_reset();
      m = 16'h8009;
      req = m;
      tick();
      for (int k = 0; k < 4; k++) begin
         g = rr_pick(ptr, m);
         chk($sformatf("rr%0d_en", k), 64'(en), 64'(onehot(g)));
         ptr = g;
         rel = 1;
         tick();
         rel = 0;
         chk($sformatf("rr%0d_gap1", k), 64'(en), 64'(0));
         tick();
         chk($sformatf("rr%0d_gap2", k), 64'(en), 64'(0));
         tick();
      end

      // Throttle at free=1, resume on pop
      do_reset();
      req = 16'(onehot(2));
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("thr_en%0d", k), 64'(en), 64'(onehot(2)));
         active = 1;
         xa = 2'($urandom); ya = 2'($urandom);
         model_push(2);
         tick();
      end
      active = 0; req = '0;
      chk("thr_off", 64'(en), 64'(0));
      chk("thr_busy", 64'(busy), 64'(1));
      chk_head("thr_h");
      evt_if.ready = 1'b1;
      tick();
      void'(evq_x.pop_front());
      void'(evq_y.pop_front());
      evt_if.ready = 1'b0;
      chk("thr_resume", 64'(en), 64'(onehot(2)));

      // Overflow: full FIFO, push without pop
      active = 1;
      for (int k = 0; k < 3; k++) begin
         xa = 2'($urandom); ya = 2'($urandom);
         if (k < 2) model_push(2);
         if (k == 2) chk("ovf_pre", 64'(ovf), 64'(0));
         tick();
      end
      active = 0;
      chk("ovf_set", 64'(ovf), 64'(1));
      tick();
      chk("ovf_sticky", 64'(ovf), 64'(1));
      drain("ovf_dr");
      chk("ovf_keep", 64'(ovf), 64'(1));
      do_reset();
      chk("ovf_clr", 64'(ovf), 64'(0));

      // Full FIFO with simultaneous pop: nothing lost
      req = 16'(onehot(9));
      tick();
      active = 1;
      for (int k = 0; k < 4; k++) begin
         xa = 2'($urandom); ya = 2'($urandom);
         model_push(9);
         tick();
      end
      chk_head("sp_h");
      evt_if.ready = 1'b1;
      xa = 2'($urandom); ya = 2'($urandom);
      model_push(9);
      tick();
      void'(evq_x.pop_front());
      void'(evq_y.pop_front());
      active = 0;
      chk("sp_noovf", 64'(ovf), 64'(0));
      drain("sp_dr");

      // Reset while granted with two events queued
      active = 1;
      tick();
      tick();
      active = 0;
      chk("mr_valid_pre", 64'(evt_if.valid), 64'(1));
      do_reset();
      req = '0;
      chk("mr_en", 64'(en), 64'(0));
      chk("mr_valid", 64'(evt_if.valid), 64'(0));
      chk("mr_busy", 64'(busy), 64'(0));

      // Randomized rounds against the queue/arith model
      for (int r = 0; r < 24; r++) begin
         m = 16'($urandom_range(1, 65535));
         req = m;
         tick();
         g = rr_pick(ptr, m);
         chk($sformatf("rnd%0d_en", r), 64'(en), 64'(onehot(g)));
         if ($urandom_range(0, 1) == 1) req = '0;
         n = $urandom_range(0, 2);
         done = 1'b0;
         for (int k = 0; k < n; k++) begin
            active = 1;
            xa = 2'($urandom); ya = 2'($urandom);
            model_push(g);
            if (k == n - 1 && $urandom_range(0, 1) == 1) begin
               rel = 1;
               done = 1'b1;
            end
            tick();
         end
         active = 0;
         if (!done) begin
            rel = 1;
            tick();
         end
         rel = 0; req = '0;
         ptr = g;
         chk($sformatf("rnd%0d_gap", r), 64'(en), 64'(0));
         tick();
         drain($sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
